axis_transmission_combiner: RTL
===============================

// Module: axis_transmission_combiner
// PURPOSE
//   Inverse of the 4-way transmission splitter: merges four narrow AXI-Stream lanes into one wide stream.
//   Lane k supplies bits [(k+1)*W-1:k*W] of tdata and [(k+1)*W/8-1:k*W/8] of tkeep, where W = IN_TDATA_WIDTH.
//   Sits after per-lane narrow processing and restores the datapath to full width.
//   Each lane has a 2-entry buffer. A registered output stage gives 1 beat/cycle throughput.
// PARAMETERS
//   IN_TDATA_WIDTH   64    lane tdata width; must be a multiple of 8
//   TUSER_WIDTH      128   tuser width, identical on all lanes and on the output
//   OUT_TDATA_WIDTH  4*IN_TDATA_WIDTH  localparam; output tdata width
// PORTS
//   axis_aclk               in   1                  single clock for all logic
//   axis_reset              in   1                  asynchronous, active-high reset
//   axis_lane_k_tdata       in   IN_TDATA_WIDTH     lane k data (k = 0..3; same set of ports per lane)
//   axis_lane_k_tkeep       in   IN_TDATA_WIDTH/8   lane k byte enables
//   axis_lane_k_tuser       in   TUSER_WIDTH        lane k sideband
//   axis_lane_k_tlast       in   1                  lane k end of packet
//   axis_lane_k_tvalid      in   1                  lane k valid
//   axis_lane_k_tready      out  1                  lane k ready
//   axis_combined_tdata     out  OUT_TDATA_WIDTH    {lane3,lane2,lane1,lane0}
//   axis_combined_tkeep     out  OUT_TDATA_WIDTH/8  {lane3,lane2,lane1,lane0} tkeep
//   axis_combined_tuser     out  TUSER_WIDTH        taken from lane 0
//   axis_combined_tlast     out  1                  taken from lane 0
//   axis_combined_tvalid    out  1                  output valid
//   axis_combined_tready    in   1                  downstream ready
//   lane_mismatch           out  1                  sticky error flag (see CONFIGURATION)
//   mismatch_count          out  16                 saturating error count (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async assert; release sampled on axis_aclk):
//     - lane buffer counts = 0; out_valid = 0; combined tdata/tkeep/tuser/tlast = 0
//     - lane_mismatch = 0; mismatch_count = 0
//     - lane tready = 1 in the first cycle after release
//     - asserting reset mid-packet discards all buffered and partial beats; no partial beat ever appears at the output
//   Lane buffer: a 2-entry FIFO per lane, holding {tdata,tkeep,tuser,tlast}.
//     - lane_k_tready = (count_k < 2); a push occurs on tvalid & tready
//     - push and pop in the same cycle on a full buffer is not possible, because tready = 0 when full
//   Merge condition: all four buffers non-empty AND (~out_valid | axis_combined_tready).
//     - on merge, pop the head of all four buffers and load the output register with the concatenation
//     - out_valid <= 1 on merge; out_valid <= 0 on a drain with no merge in the same cycle
//   Ordering and latency:
//     - lanes are merged strictly in arrival order per lane, with no cross-lane reordering
//     - last of the four lane beats accepted at edge N -> axis_combined_tvalid = 1 after edge N+1
//   Throughput and flow control:
//     - sustained 1 output beat/cycle when all lanes stream and downstream is ready
//     - a lane that runs ahead by 2 beats is back-pressured (tready = 0) until the others catch up
//     - combined outputs are held stable while tvalid = 1 and tready = 0 (AXIS rule)
//   A lane tkeep of zero is passed through unchanged; no compaction is performed.
// CONFIGURATION
//   Macro AXIS_COMBINER_CHECK_EN.
//   Defined:
//     - on each merge, compare tlast and tuser of lanes 1..3 against lane 0
//     - any difference sets lane_mismatch = 1 (sticky until reset)
//     - the same difference increments mismatch_count, saturating at 16'hFFFF
//     - the merged beat is still emitted, using lane 0 tlast and tuser
//   Not defined:
//     - no comparison logic is built
//     - lane_mismatch and mismatch_count are tied to 0
// TESTING
//   1. Reset, then one beat per lane: lane k tdata = 64'h1111_1111_1111_1111*(k+1), all tkeep = 8'hFF,
//      tlast = 1, all accepted at the same edge
//      -> tvalid one cycle later; tdata = {4444..,3333..,2222..,1111..}; tkeep = 32'hFFFF_FFFF; tlast = 1.
//   2. Streaming: 100 beats on all lanes, combined tready = 1
//      -> 100 output beats in 100 consecutive cycles; data in order; lane tready never drops.
//   3. Lane skew: lane 2 held idle while lanes 0, 1 and 3 send 3 beats each
//      -> each of those lanes' tready = 0 after 2 accepted beats; no output until lane 2 sends;
//      afterwards the output order is correct.
//   4. Back-pressure: combined tready = 0 for 5 cycles with output valid
//      -> output held stable; every lane fills to 2 and then deasserts tready; no beat is lost after release.
//   5. Reset mid-packet: assert axis_reset with 2 beats buffered in each lane and out_valid = 1
//      -> tvalid = 0 immediately; after release the next output contains only new data.
//   6. With AXIS_COMBINER_CHECK_EN: lane 3 tlast = 0 while lane 0 tlast = 1, on 2 beats
//      -> both beats are emitted with tlast = 1; lane_mismatch = 1; mismatch_count = 2.
//      Without the macro, both outputs stay 0.

Source files
------------

// File: rtl/axis_transmission_combiner.sv
// Merges four narrow AXI-Stream lanes into one wide stream through 2-entry lane FIFOs and a registered output.
// Define AXIS_COMBINER_CHECK_EN to build the lane tlast/tuser consistency checker.
module axis_transmission_combiner #(
    parameter int IN_TDATA_WIDTH = 64,
    parameter int TUSER_WIDTH    = 128
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic [IN_TDATA_WIDTH-1:0]     axis_lane_0_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]   axis_lane_0_tkeep,
    input  logic [TUSER_WIDTH-1:0]        axis_lane_0_tuser,
    input  logic                          axis_lane_0_tlast,
    input  logic                          axis_lane_0_tvalid,
    output logic                          axis_lane_0_tready,
    input  logic [IN_TDATA_WIDTH-1:0]     axis_lane_1_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]   axis_lane_1_tkeep,
    input  logic [TUSER_WIDTH-1:0]        axis_lane_1_tuser,
    input  logic                          axis_lane_1_tlast,
    input  logic                          axis_lane_1_tvalid,
    output logic                          axis_lane_1_tready,
    input  logic [IN_TDATA_WIDTH-1:0]     axis_lane_2_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]   axis_lane_2_tkeep,
    input  logic [TUSER_WIDTH-1:0]        axis_lane_2_tuser,
    input  logic                          axis_lane_2_tlast,
    input  logic                          axis_lane_2_tvalid,
    output logic                          axis_lane_2_tready,
    input  logic [IN_TDATA_WIDTH-1:0]     axis_lane_3_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]   axis_lane_3_tkeep,
    input  logic [TUSER_WIDTH-1:0]        axis_lane_3_tuser,
    input  logic                          axis_lane_3_tlast,
    input  logic                          axis_lane_3_tvalid,
    output logic                          axis_lane_3_tready,
    output logic [4*IN_TDATA_WIDTH-1:0]   axis_combined_tdata,
    output logic [4*IN_TDATA_WIDTH/8-1:0] axis_combined_tkeep,
    output logic [TUSER_WIDTH-1:0]        axis_combined_tuser,
    output logic                          axis_combined_tlast,
    output logic                          axis_combined_tvalid,
    input  logic                          axis_combined_tready,
    output logic                          lane_mismatch,
    output logic [15:0]                   mismatch_count
);

    localparam int OUT_TDATA_WIDTH = 4*IN_TDATA_WIDTH;
    localparam int KW     = IN_TDATA_WIDTH/8;
    localparam int SB_LSB = IN_TDATA_WIDTH + KW;
    localparam int EW     = SB_LSB + TUSER_WIDTH + 1;

    // FIFO entry layout, LSB first: tdata, tkeep, tuser, tlast
    logic [EW-1:0] lane_in [4];
    logic [EW-1:0] mem_q   [4][2];
    logic [EW-1:0] head    [4];
    logic [1:0]    cnt_q   [4];
    logic [1:0]    cnt_d   [4];
    logic [3:0]    lane_vld, lane_rdy, push, nonempty;
    logic [3:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          merge;

    logic                       out_valid_q, out_valid_d;
    logic [OUT_TDATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [4*KW-1:0]            out_keep_q, out_keep_d;
    logic [TUSER_WIDTH-1:0]     out_user_q, out_user_d;
    logic                       out_last_q, out_last_d;

    assign lane_in[0] = {axis_lane_0_tlast, axis_lane_0_tuser, axis_lane_0_tkeep, axis_lane_0_tdata};
    assign lane_in[1] = {axis_lane_1_tlast, axis_lane_1_tuser, axis_lane_1_tkeep, axis_lane_1_tdata};
    assign lane_in[2] = {axis_lane_2_tlast, axis_lane_2_tuser, axis_lane_2_tkeep, axis_lane_2_tdata};
    assign lane_in[3] = {axis_lane_3_tlast, axis_lane_3_tuser, axis_lane_3_tkeep, axis_lane_3_tdata};
    assign lane_vld   = {axis_lane_3_tvalid, axis_lane_2_tvalid, axis_lane_1_tvalid, axis_lane_0_tvalid};

    assign axis_lane_0_tready = lane_rdy[0];
    assign axis_lane_1_tready = lane_rdy[1];
    assign axis_lane_2_tready = lane_rdy[2];
    assign axis_lane_3_tready = lane_rdy[3];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_rdy[k] = (cnt_q[k] < 2'd2);
            push[k]     = lane_vld[k] & lane_rdy[k];
            nonempty[k] = (cnt_q[k] != 2'd0);
            head[k]     = mem_q[k][rd_ptr_q[k]];
        end
        // A beat leaves only when every lane has one and the output slot is free or draining
        merge = (&nonempty) & (~out_valid_q | axis_combined_tready);
        for (int k = 0; k < 4; k++) begin
            cnt_d[k]    = cnt_q[k] + {1'b0, push[k]} - {1'b0, merge};
            wr_ptr_d[k] = wr_ptr_q[k] ^ push[k];
            rd_ptr_d[k] = rd_ptr_q[k] ^ merge;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_user_d  = out_user_q;
        out_last_d  = out_last_q;
        if (merge) begin
            out_valid_d = 1'b1;
            out_data_d  = {head[3][IN_TDATA_WIDTH-1:0], head[2][IN_TDATA_WIDTH-1:0],
                           head[1][IN_TDATA_WIDTH-1:0], head[0][IN_TDATA_WIDTH-1:0]};
            out_keep_d  = {head[3][IN_TDATA_WIDTH +: KW], head[2][IN_TDATA_WIDTH +: KW],
                           head[1][IN_TDATA_WIDTH +: KW], head[0][IN_TDATA_WIDTH +: KW]};
            out_user_d  = head[0][SB_LSB +: TUSER_WIDTH];
            out_last_d  = head[0][EW-1];
        end else if (axis_combined_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= 2'd0;
            wr_ptr_q    <= 4'd0;
            rd_ptr_q    <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_user_q  <= out_user_d;
            out_last_q  <= out_last_d;
        end
    end

    // Storage needs no reset: occupancy counts decide what is valid
    always_ff @(posedge axis_aclk) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= lane_in[k];
        end
    end

    assign axis_combined_tvalid = out_valid_q;
    assign axis_combined_tdata  = out_data_q;
    assign axis_combined_tkeep  = out_keep_q;
    assign axis_combined_tuser  = out_user_q;
    assign axis_combined_tlast  = out_last_q;

`ifdef AXIS_COMBINER_CHECK_EN
    logic        side_diff;
    logic        mismatch_q, mismatch_d;
    logic [15:0] mcount_q, mcount_d;

    always_comb begin
        side_diff = 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (head[k][EW-1:SB_LSB] != head[0][EW-1:SB_LSB]) side_diff = 1'b1;
        end
        mismatch_d = mismatch_q;
        mcount_d   = mcount_q;
        if (merge && side_diff) begin
            mismatch_d = 1'b1;
            if (mcount_q != 16'hFFFF) mcount_d = mcount_q + 16'd1;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            mismatch_q <= 1'b0;
            mcount_q   <= 16'd0;
        end else begin
            mismatch_q <= mismatch_d;
            mcount_q   <= mcount_d;
        end
    end

    assign lane_mismatch  = mismatch_q;
    assign mismatch_count = mcount_q;
`else
    // Sideband of lanes 1..3 is carried but deliberately dropped when checking is off
    logic unused_lane_sideband;
    assign unused_lane_sideband = ^{head[1][EW-1:SB_LSB], head[2][EW-1:SB_LSB], head[3][EW-1:SB_LSB]};
    assign lane_mismatch  = 1'b0;
    assign mismatch_count = 16'd0;
`endif

endmodule
